// File: rtl/inference_controller_if.sv
// Host and network-side control bundle for the inference controller.
// The controller takes the slave side; the host/stimulus takes master.
interface inference_controller_if #(
    parameter int N_STEPS_W    = 8,
    parameter int OUTPUT_WIDTH = 4
);
    logic                    start_valid;
    logic                    start_ready;
    logic [N_STEPS_W-1:0]    n_steps;
    logic                    abort;
    logic                    layer_clear;
    logic                    step_en;
    logic                    win_valid;
    logic                    ol_valid;
    logic [OUTPUT_WIDTH-1:0] ol_result;
    logic                    res_valid;
    logic                    res_ready;
    logic [OUTPUT_WIDTH-1:0] res_data;
    logic                    res_err;
    logic                    busy;

    modport master (
        output start_valid, n_steps, abort,
        output ol_valid, ol_result, res_ready,
        input  start_ready, layer_clear, step_en, win_valid,
        input  res_valid, res_data, res_err, busy
    );

    modport slave (
        input  start_valid, n_steps, abort,
        input  ol_valid, ol_result, res_ready,
        output start_ready, layer_clear, step_en, win_valid,
        output res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/inference_controller.sv
// Sequences one spiking-network inference per host request:
// clear, timestep window, watchdog-bounded wait, held result.
module inference_controller #(
    parameter int N_STEPS_W    = 8,
    parameter int CLEAR_CYCLES = 2,
    parameter int TIMEOUT      = 15,
    parameter int OUTPUT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    inference_controller_if.slave bus
);
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WAIT,
        HOLD,
        ABORT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [N_STEPS_W-1:0]    steps;
    logic [N_STEPS_W-1:0]    step_cnt;
    logic [CLR_W-1:0]        clr_cnt;
    logic [TMO_W-1:0]        wait_cnt;
    logic [OUTPUT_WIDTH-1:0] res_data_q;
    logic                    res_err_q;

    logic clr_done;
    logic run_done;
    logic tmo;

    assign clr_done = (clr_cnt == CLR_LAST);
    assign run_done = (step_cnt == steps - 1'b1);
    assign tmo      = (wait_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort takes priority over every other exit of the active states
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start_valid) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (bus.abort)     state_nxt = ABORT;
                else if (clr_done) state_nxt = RUN;
            end
            RUN: begin
                if (bus.abort)     state_nxt = ABORT;
                else if (run_done) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.abort)                  state_nxt = ABORT;
                else if (bus.ol_valid || tmo)   state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            ABORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // each counter restarts on any state change and saturates at its end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt  <= '0;
            step_cnt <= '0;
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            clr_cnt  <= '0;
            step_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == CLEAR && !clr_done) clr_cnt  <= clr_cnt + 1'b1;
            if (state == RUN && !run_done)   step_cnt <= step_cnt + 1'b1;
            if (state == WAIT && !tmo)       wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps <= '0;
        end else if (state == IDLE && bus.start_valid) begin
            steps <= (bus.n_steps == '0) ? N_STEPS_W'(1) : bus.n_steps;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else if (state == WAIT && !bus.abort) begin
            if (bus.ol_valid) begin
                res_data_q <= bus.ol_result;
                res_err_q  <= 1'b0;
            end else if (tmo) begin
                res_data_q <= '0;
                res_err_q  <= 1'b1;
            end
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.layer_clear = (state == CLEAR) || (state == ABORT);
    assign bus.step_en     = (state == RUN);
    assign bus.win_valid   = (state == RUN);
    assign bus.res_valid   = (state == HOLD);
    assign bus.res_data    = res_data_q;
    assign bus.res_err     = res_err_q;
endmodule

// File: tb/tb_inference_controller.sv
// Directed bench for inference_controller: window lengths, result
// paths, watchdog, backpressure, abort and asynchronous reset.
module tb_inference_controller;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inference_controller_if #(.N_STEPS_W(8), .OUTPUT_WIDTH(4)) bus ();

    inference_controller #(
        .N_STEPS_W   (8),
        .CLEAR_CYCLES(2),
        .TIMEOUT     (15),
        .OUTPUT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [7:0] n);
        bus.start_valid = 1'b1;
        bus.n_steps     = n;
        tick();
        bus.start_valid = 1'b0;
    endtask

    task automatic count_window(output int nclr, output int nwin,
                                output int nstep);
        nclr  = 0;
        nwin  = 0;
        nstep = 0;
        for (int i = 0; i < 50 && bus.layer_clear; i++) begin
            nclr++;
            tick();
        end
        for (int i = 0; i < 300 && bus.win_valid; i++) begin
            nwin++;
            if (bus.step_en) nstep++;
            tick();
        end
    endtask

    task automatic wait_res(input int ol_at, input logic [3:0] r,
                            output int w);
        w = 0;
        while (!bus.res_valid && w < 40) begin
            w++;
            bus.ol_valid  = (w == ol_at);
            bus.ol_result = r;
            tick();
        end
        bus.ol_valid = 1'b0;
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("acc_res_valid", 32'(bus.res_valid), 0);
        chk("acc_start_ready", 32'(bus.start_ready), 1);
    endtask

    int nclr;
    int nwin;
    int nstep;
    int w;

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        bus.start_valid = 1'b0;
        bus.n_steps     = '0;
        bus.abort       = 1'b0;
        bus.ol_valid    = 1'b0;
        bus.ol_result   = '0;
        bus.res_ready   = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_start_ready", 32'(bus.start_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_layer_clear", 32'(bus.layer_clear), 0);
        chk("rst_win_valid", 32'(bus.win_valid), 0);
        chk("rst_res_data", 32'(bus.res_data), 0);
        chk("rst_res_err", 32'(bus.res_err), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // basic run, result three wait cycles after the window
        start_req(8'd4);
        chk("b_busy", 32'(bus.busy), 1);
        count_window(nclr, nwin, nstep);
        chk("b_clear_cycles", 32'(nclr), 2);
        chk("b_win_cycles", 32'(nwin), 4);
        chk("b_step_cycles", 32'(nstep), 4);
        wait_res(3, 4'd7, w);
        chk("b_wait_cycles", 32'(w), 3);
        chk("b_res_valid", 32'(bus.res_valid), 1);
        chk("b_res_data", 32'(bus.res_data), 7);
        chk("b_res_err", 32'(bus.res_err), 0);
        accept();

        // zero steps runs a one-cycle window
        start_req(8'd0);
        count_window(nclr, nwin, nstep);
        chk("z_clear_cycles", 32'(nclr), 2);
        chk("z_win_cycles", 32'(nwin), 1);
        wait_res(1, 4'd5, w);
        chk("z_wait_cycles", 32'(w), 1);
        chk("z_res_data", 32'(bus.res_data), 5);
        accept();

        // watchdog expiry
        start_req(8'd2);
        count_window(nclr, nwin, nstep);
        chk("t_win_cycles", 32'(nwin), 2);
        wait_res(0, 4'd9, w);
        chk("t_wait_cycles", 32'(w), 15);
        chk("t_res_valid", 32'(bus.res_valid), 1);
        chk("t_res_data", 32'(bus.res_data), 0);
        chk("t_res_err", 32'(bus.res_err), 1);
        accept();

        // ol_valid in the expiry cycle beats the timeout
        start_req(8'd1);
        count_window(nclr, nwin, nstep);
        wait_res(15, 4'd3, w);
        chk("e_wait_cycles", 32'(w), 15);
        chk("e_res_data", 32'(bus.res_data), 3);
        chk("e_res_err", 32'(bus.res_err), 0);
        accept();

        // backpressure with a pending start request
        start_req(8'd3);
        count_window(nclr, nwin, nstep);
        wait_res(2, 4'd9, w);
        chk("p_res_valid", 32'(bus.res_valid), 1);
        bus.start_valid = 1'b1;
        bus.n_steps     = 8'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("p_hold_valid", 32'(bus.res_valid), 1);
            chk("p_hold_data", 32'(bus.res_data), 9);
            chk("p_hold_err", 32'(bus.res_err), 0);
            chk("p_start_ready", 32'(bus.start_ready), 0);
            chk("p_no_clear", 32'(bus.layer_clear), 0);
            chk("p_no_win", 32'(bus.win_valid), 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("p_rel_valid", 32'(bus.res_valid), 0);
        chk("p_rel_ready", 32'(bus.start_ready), 1);
        tick();
        bus.start_valid = 1'b0;
        chk("p_next_clear", 32'(bus.layer_clear), 1);
        chk("p_next_busy", 32'(bus.start_ready), 0);
        count_window(nclr, nwin, nstep);
        chk("p_next_clears", 32'(nclr), 2);
        chk("p_next_win", 32'(nwin), 2);
        wait_res(1, 4'd1, w);
        chk("p_next_data", 32'(bus.res_data), 1);
        accept();

        // abort at RUN step 2
        start_req(8'd6);
        tick();
        tick();
        chk("a_run_win", 32'(bus.win_valid), 1);
        tick();
        tick();
        chk("a_run_step2", 32'(bus.step_en), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("a_win_drop", 32'(bus.win_valid), 0);
        chk("a_step_drop", 32'(bus.step_en), 0);
        chk("a_clear_pulse", 32'(bus.layer_clear), 1);
        chk("a_pulse_busy", 32'(bus.busy), 1);
        tick();
        chk("a_idle_ready", 32'(bus.start_ready), 1);
        chk("a_idle_clear", 32'(bus.layer_clear), 0);
        chk("a_no_res", 32'(bus.res_valid), 0);
        tick();
        chk("a_still_no_res", 32'(bus.res_valid), 0);

        // abort during WAIT
        start_req(8'd1);
        count_window(nclr, nwin, nstep);
        tick();
        chk("aw_waiting", 32'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("aw_clear_pulse", 32'(bus.layer_clear), 1);
        chk("aw_no_res", 32'(bus.res_valid), 0);
        tick();
        chk("aw_idle_ready", 32'(bus.start_ready), 1);
        chk("aw_idle_res", 32'(bus.res_valid), 0);
        chk("aw_idle_clear", 32'(bus.layer_clear), 0);

        // asynchronous reset in the middle of a window
        start_req(8'd8);
        tick();
        tick();
        tick();
        chk("r_in_run", 32'(bus.win_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("r_win_valid", 32'(bus.win_valid), 0);
        chk("r_step_en", 32'(bus.step_en), 0);
        chk("r_start_ready", 32'(bus.start_ready), 1);
        chk("r_busy", 32'(bus.busy), 0);
        chk("r_res_data", 32'(bus.res_data), 0);
        chk("r_res_valid", 32'(bus.res_valid), 0);
        #2 rst = 1'b0;
        tick();
        start_req(8'd3);
        count_window(nclr, nwin, nstep);
        chk("r2_clear_cycles", 32'(nclr), 2);
        chk("r2_win_cycles", 32'(nwin), 3);
        wait_res(2, 4'd4, w);
        chk("r2_wait_cycles", 32'(w), 2);
        chk("r2_res_data", 32'(bus.res_data), 4);
        chk("r2_res_err", 32'(bus.res_err), 0);
        accept();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inference_controller.md
# inference_controller

Sequences one spiking-network inference per host request. It clears the network and spike counters, then opens an input window of a programmed number of timesteps. It waits for the output layer's class decision, bounded by a watchdog, and returns the result to the host over a valid/ready handshake with backpressure. It sits between the host/stimulus interface and the network plus output layer, generating their clear, step and window-valid controls.

## Interface
- N_STEPS_W, 8, width of the timestep count; maximum n_steps is 2^N_STEPS_W-1
- CLEAR_CYCLES, 2, cycles layer_clear is held before each window (≥1)
- TIMEOUT, 15, maximum WAIT cycles for ol_valid before declaring an error (≥1)
- OUTPUT_WIDTH, 4, width of the class index

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  host requests an inference
- start_ready  out  1  controller can accept a request (IDLE only)
- n_steps  in  N_STEPS_W  timesteps for this inference; sampled on start handshake
- abort  in  1  cancel the current inference
- layer_clear  out  1  clears neuron state and output-layer counters
- step_en  out  1  advances network one timestep
- win_valid  out  1  window valid to the output layer
- ol_valid  in  1  output-layer result strobe
- ol_result  in  OUTPUT_WIDTH  output-layer class index
- res_valid  out  1  result available
- res_ready  in  1  host accepts result
- res_data  out  OUTPUT_WIDTH  class index
- res_err  out  1  result produced by timeout, not by ol_valid
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CLEAR, RUN, WAIT, HOLD, ABORT. Outputs are Moore-decoded from the state register except res_data and res_err, which are registers.
- IDLE: start_ready=1. On start_valid, latch steps=(n_steps==0 ? 1 : n_steps) and go to CLEAR.
- CLEAR: layer_clear=1 for exactly CLEAR_CYCLES cycles, then go to RUN.
- RUN: win_valid=1 and step_en=1. The step counter counts 0..steps-1; after the cycle with counter==steps-1, go to WAIT. The window is exactly `steps` consecutive cycles.
- WAIT: win_valid=0. The timer counts WAIT cycles.
  - On ol_valid: latch res_data=ol_result, res_err=0, go to HOLD.
  - If the timer reaches TIMEOUT without ol_valid: res_data=0, res_err=1, go to HOLD.
  - ol_valid in the expiry cycle wins over the timeout.
- HOLD: res_valid=1. res_data and res_err are stable. On res_ready, go to IDLE.
- abort in CLEAR, RUN or WAIT: go to ABORT next edge. ABORT asserts layer_clear for one cycle, then goes to IDLE. No res_valid is produced.
- abort is ignored in IDLE and HOLD.
- ol_valid outside WAIT is ignored. start_valid outside IDLE is ignored; there is no queueing.
- Counters saturate at their terminal values and never wrap inside a state.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, start_ready=1, busy=0
  - all other outputs 0, including res_data=0 and res_err=0
  - counters cleared
- Start handshake at edge k: CLEAR occupies cycles k+1..k+CLEAR_CYCLES. RUN occupies the next `steps` cycles.
- WAIT begins the cycle after the last RUN cycle.
- Result is visible as res_valid in the cycle after the ol_valid sample or after timer expiry.
- Latency from start handshake to res_valid = CLEAR_CYCLES + steps + w + 1, where w is the number of WAIT cycles (≤TIMEOUT).
- Result handshake at edge m: res_valid=0 and start_ready=1 from cycle m+1. The next start can be accepted at edge m+1.
- An abort sampled at edge a: layer_clear=1 in cycle a+1, IDLE from a+2. win_valid and step_en drop at a+1.
- Reset asserted mid-RUN drops win_valid and step_en immediately. No result is emitted.

## Test plan
- Basic run (n_steps=4, CLEAR_CYCLES=2), with ol_valid/ol_result=7 driven 3 cycles after the window closes:
  - layer_clear is high for 2 cycles, then win_valid and step_en are high for exactly 4 cycles.
  - res_valid then shows res_data=7, res_err=0.
- n_steps=0: win_valid is high for exactly 1 cycle; the rest of the flow is normal.
- No ol_valid: after 15 WAIT cycles, res_valid shows res_data=0, res_err=1.
- ol_valid arriving in the 15th WAIT cycle (ol_result=3): res_data=3, res_err=0.
- Backpressure, with res_ready low for 10 cycles and start_valid held high:
  - res_valid, res_data and res_err stay stable; start_ready=0; no new window starts.
  - After res_ready, start_ready=1 next cycle and the new request is accepted.
- abort at RUN step 2 → win_valid drops next cycle, a single layer_clear pulse follows, then IDLE with no res_valid. Repeat the same check with abort during WAIT.
- rst asserted mid-RUN between clock edges → all outputs take reset values immediately, start_ready=1. A subsequent normal run completes correctly.
